// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
//   Boot sequencer for the instruction-fetch stage. Holds the core, receives a
//   program as a byte stream, packs bytes big-endian into 32-bit words, and
//   writes them to IMem at word addresses 0,1,2,... The write address is the
//   fetch PC itself: the PC is parked on the current address while bytes
//   arrive, then stepped by 4 on each write. After loading, the PC is reset to
//   0 and the core is released, with the core's next-PC forwarded to fetch.
//   A valid start while running aborts execution and reloads.
//
// Ports
//   CLK, RST        clock; synchronous active-low reset
//   start           one-cycle pulse requesting a load (honoured in IDLE/RUN)
//   word_count      words to load, sampled with an accepted start
//   rx_data/valid   program byte stream; rx_ready = byte consumed this cycle
//   core_newpc      next PC from the core datapath (forwarded in RUN)
//   if_rst/if_we    PC reset / IMem write enable to fetch
//   if_wins         IMem write data
//   if_newpc        PC load value to fetch
//   if_pc           current fetch PC (assertion checks only)
//   core_run        core may update architectural state
//   busy            load or boot in progress
//   err             sticky: last start rejected for word_count > IMEM_WORDS
module imem_boot_ctrl #(
    parameter int IMEM_WORDS = 64,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [31:0]      core_newpc,
    output logic             if_rst,
    output logic             if_we,
    output logic [31:0]      if_wins,
    output logic [31:0]      if_newpc,
    input  logic [31:0]      if_pc,
    output logic             core_run,
    output logic             busy,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(IMEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RECV, S_WRITE, S_BOOT, S_RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_q;     // latched word_count
    logic [CNT_W-1:0] wcnt_q;    // words written so far
    logic [CNT_W-1:0] wcnt_nxt;
    logic [1:0]       bidx_q;    // byte index within current word
    logic [31:0]      word_q;    // byte assembly shift register
    logic [31:0]      addr_q;    // byte address of the word being assembled
    logic             err_q;
    logic             cnt_ok;
    logic             start_ok;

    assign cnt_ok   = (word_count <= MAX_WORDS);
    assign start_ok = start && cnt_ok && (state == S_IDLE || state == S_RUN);
    assign wcnt_nxt = wcnt_q + CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= S_IDLE;
            cnt_q  <= '0;
            wcnt_q <= '0;
            bidx_q <= '0;
            word_q <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_RUN: begin
                    if (start) begin
                        if (!cnt_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= 1'b0;
                            cnt_q <= word_count;
                            state <= S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    wcnt_q <= '0;
                    addr_q <= '0;
                    bidx_q <= '0;
                    state  <= (cnt_q == '0) ? S_BOOT : S_RECV;
                end
                S_RECV: begin
                    if (rx_valid) begin
                        word_q <= {word_q[23:0], rx_data};
                        bidx_q <= bidx_q + 2'd1;
                        if (bidx_q == 2'd3)
                            state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wcnt_q <= wcnt_nxt;
                    addr_q <= addr_q + 32'd4;
                    bidx_q <= '0;
                    state  <= (wcnt_nxt == cnt_q) ? S_BOOT : S_RECV;
                end
                S_BOOT:  state <= S_RUN;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state. core_run alone also looks at
    // start so that an abort-and-reload stops the core in the start cycle.
    always_comb begin
        rx_ready = 1'b0;
        if_rst   = 1'b0;
        if_we    = 1'b0;
        if_wins  = '0;
        if_newpc = '0;
        core_run = 1'b0;
        busy     = 1'b0;
        case (state)
            S_IDLE: if_rst = 1'b1;
            S_CLR: begin
                if_rst = 1'b1;
                busy   = 1'b1;
            end
            S_RECV: begin
                rx_ready = 1'b1;
                if_newpc = addr_q;          // park PC on the target word
                busy     = 1'b1;
            end
            S_WRITE: begin
                if_we    = 1'b1;
                if_wins  = word_q;
                if_newpc = addr_q + 32'd4;
                busy     = 1'b1;
            end
            S_BOOT: begin
                if_rst = 1'b1;
                busy   = 1'b1;
            end
            S_RUN: begin
                if_newpc = core_newpc;
                core_run = !start_ok;
            end
            default: if_rst = 1'b1;
        endcase
    end

    assign err = err_q;

    always @(posedge CLK) begin
        if (RST) begin
            if (state == S_WRITE)
                assert (if_pc == addr_q);
            assert (!(if_we && if_rst));
            assert (!(core_run && busy));
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;

    localparam int IMEM_WORDS = 64;
    localparam int CNT_W      = 16;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] word_count = '0;
    logic [7:0]       rx_data = '0;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic [31:0]      core_newpc = '0;
    logic             if_rst, if_we, core_run, busy, err;
    logic [31:0]      if_wins, if_newpc;
    logic [31:0]      pc = '0;

    int checks = 0;
    int errors = 0;

    imem_boot_ctrl #(.IMEM_WORDS(IMEM_WORDS), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .word_count(word_count),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .core_newpc(core_newpc), .if_rst(if_rst), .if_we(if_we),
        .if_wins(if_wins), .if_newpc(if_newpc), .if_pc(pc),
        .core_run(core_run), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    // Fetch-stage model plus a log of every IMem write.
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [31:0] imem [0:IMEM_WORDS-1];

    always @(posedge CLK) begin
        if (if_we && !if_rst) begin
            imem[pc[7:2]] <= if_wins;
            wr_addr.push_back(pc);
            wr_data.push_back(if_wins);
        end
        pc <= if_rst ? 32'd0 : if_newpc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [7:0] prog [$];
    logic       run_at_start;

    // Issue start, then feed prog; returns edges from the start edge until
    // core_run is seen high (-1 on timeout).
    task automatic do_load(input int cnt, input bit toggle, output int lat);
        int  idx;
        bit  v, acc;
        idx = 0;
        lat = -1;
        @(negedge CLK);
        start = 1'b1;
        word_count = CNT_W'(cnt);
        rx_valid = !toggle && prog.size() > 0;
        rx_data  = (prog.size() > 0) ? prog[0] : 8'h00;
        #1 run_at_start = core_run;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        for (int e = 1; e <= 1000; e++) begin
            if (core_run) begin
                lat = e - 1;
                break;
            end
            v = (idx < prog.size()) && (!toggle || (e % 2 == 1));
            rx_valid = v;
            rx_data  = v ? prog[idx] : 8'h00;
            acc = v && rx_ready;
            @(posedge CLK);
            if (acc) idx++;
            @(negedge CLK);
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        int lat;

        // Reset with bytes on offer.
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst if_rst", 32'(if_rst), 32'd1);
        chk("rst if_we", 32'(if_we), 32'd0);
        chk("rst core_run", 32'(core_run), 32'd0);
        chk("rst rx_ready", 32'(rx_ready), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        RST = 1'b1;
        rx_valid = 1'b0;

        // Two-word load, continuous stream.
        prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
        do_load(2, 1'b0, lat);
        chk("load2 latency", 32'(lat), 32'd12);
        chk("load2 nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("load2 addr0", wr_addr[0], 32'h0);
            chk("load2 data0", wr_data[0], 32'h20080005);
            chk("load2 addr1", wr_addr[1], 32'h4);
            chk("load2 data1", wr_data[1], 32'hAC010000);
        end
        chk("load2 imem1", imem[1], 32'hAC010000);
        chk("load2 busy", 32'(busy), 32'd0);
        core_newpc = 32'h0000_0040;
        #1;
        chk("run newpc fwd", if_newpc, 32'h0000_0040);
        chk("run if_rst", 32'(if_rst), 32'd0);

        // Reload from RUN with rx_valid on every other cycle.
        wr_addr.delete();
        wr_data.delete();
        do_load(2, 1'b1, lat);
        chk("reload run drop", 32'(run_at_start), 32'd0);
        chk("bp latency", 32'(lat), 32'd19);
        chk("bp nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("bp addr0", wr_addr[0], 32'h0);
            chk("bp data0", wr_data[0], 32'h20080005);
            chk("bp addr1", wr_addr[1], 32'h4);
            chk("bp data1", wr_data[1], 32'hAC010000);
        end

        // Zero-word load from RUN.
        wr_addr.delete();
        wr_data.delete();
        prog.delete();
        do_load(0, 1'b0, lat);
        chk("zero run drop", 32'(run_at_start), 32'd0);
        chk("zero latency", 32'(lat), 32'd2);
        chk("zero nwr", 32'(wr_addr.size()), 32'd0);

        // Oversized start while running: flagged, core keeps running.
        @(negedge CLK);
        start = 1'b1;
        word_count = CNT_W'(100);
        #1;
        chk("bad run core_run", 32'(core_run), 32'd1);
        @(negedge CLK);
        start = 1'b0;
        chk("bad run err", 32'(err), 32'd1);
        chk("bad run stays", 32'(core_run), 32'd1);

        // Reset, then an oversized start from IDLE.
        RST = 1'b0;
        @(negedge CLK);
        chk("rst clears err", 32'(err), 32'd0);
        RST = 1'b1;
        start = 1'b1;
        word_count = CNT_W'(IMEM_WORDS + 1);
        @(negedge CLK);
        start = 1'b0;
        repeat (2) @(negedge CLK);
        chk("bad idle err", 32'(err), 32'd1);
        chk("bad idle if_rst", 32'(if_rst), 32'd1);
        chk("bad idle busy", 32'(busy), 32'd0);
        chk("bad idle rx_ready", 32'(rx_ready), 32'd0);

        // Full-depth load.
        wr_addr.delete();
        wr_data.delete();
        prog.delete();
        for (int i = 0; i < IMEM_WORDS; i++) begin
            prog.push_back(8'(i));
            prog.push_back(8'(i) ^ 8'h5A);
            prog.push_back(8'hC3);
            prog.push_back(8'(255 - i));
        end
        do_load(IMEM_WORDS, 1'b0, lat);
        chk("full latency", 32'(lat), 32'd322);
        chk("full err cleared", 32'(err), 32'd0);
        chk("full nwr", 32'(wr_addr.size()), 32'd64);
        if (wr_addr.size() == 64) begin
            chk("full data0", wr_data[0], 32'h005AC3FF);
            chk("full last addr", wr_addr[63], 32'd252);
            chk("full last data", wr_data[63], 32'h3F65C3C0);
        end
        chk("full imem63", imem[63], 32'h3F65C3C0);

        // Reset after two bytes of a one-word load.
        @(negedge CLK);
        start = 1'b1;
        word_count = CNT_W'(1);
        rx_valid = 1'b1;
        rx_data = 8'h11;
        @(negedge CLK);                     // CLR
        start = 1'b0;
        @(negedge CLK);                     // RECV, byte 0 on offer
        chk("mid rx_ready", 32'(rx_ready), 32'd1);
        @(negedge CLK);                     // byte 0 taken
        rx_data = 8'h22;
        @(negedge CLK);                     // byte 1 taken
        RST = 1'b0;
        rx_data = 8'h33;
        @(negedge CLK);
        chk("mid rst if_rst", 32'(if_rst), 32'd1);
        chk("mid rst rx_ready", 32'(rx_ready), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        RST = 1'b1;
        rx_valid = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        prog = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_load(1, 1'b0, lat);
        chk("after rst latency", 32'(lat), 32'd7);
        chk("after rst nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("after rst addr", wr_addr[0], 32'h0);
            chk("after rst data", wr_data[0], 32'hDEADBEEF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Sequences the instruction-fetch stage. Owns its PC-load (newPC), write-enable/write-data and PC-reset inputs.
- After reset the core is held. On start, receives a program as a byte stream (valid/ready), packs it into 32-bit words and writes them to IMem at consecutive word addresses from 0.
- Then resets the fetch PC to 0 and releases the core, forwarding the core's next-PC to the fetch stage.
- A start during RUN aborts execution and reloads.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in words; upper bound for word_count.
- CNT_W, 16, width of word_count and internal word counter.

Ports:
- CLK  input  1  clock
- RST  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse: begin load
- word_count  input  CNT_W  words to load, sampled on accepted start
- rx_data  input  8  program byte, big-endian within word
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  controller accepts byte this cycle
- core_newpc  input  32  next PC from core datapath
- if_rst  output  1  active-high PC reset to fetch stage
- if_we  output  1  IMem write enable to fetch stage
- if_wins  output  32  IMem write data
- if_newpc  output  32  PC load value to fetch stage
- if_pc  input  32  current fetch PC, used only for assertion checks
- core_run  output  1  core may update architectural state
- busy  output  1  load or boot in progress
- err  output  1  sticky: start rejected due to word_count > IMEM_WORDS

Behaviour:
- Fetch stage contract:
  - On each posedge, fetch writes IMem[PC>>2] if if_we=1 and if_rst=0.
  - Then PC <= 0 if if_rst=1, else PC <= if_newpc.
- States: IDLE, CLR, RECV, WRITE, BOOT, RUN. State register is reset synchronously.
- RST=0 at posedge:
  - state=IDLE, counters=0, byte index=0, shift register=0, err=0.
  - Reset overrides everything, including mid-load.
  - Partially written IMem contents are not restored.
- IDLE: if_rst=1, if_we=0, rx_ready=0, core_run=0, busy=0, if_newpc=0, if_wins=0.
  - On start with word_count > IMEM_WORDS: err<=1, stay IDLE.
  - On start with valid word_count: latch it, err<=0, go CLR.
- CLR (1 cycle): if_rst=1, busy=1 → PC=0.
  - If latched count==0 → BOOT, else → RECV.
- RECV: rx_ready=1, if_rst=0, if_we=0, if_newpc=addr (PC held), busy=1.
  - Each rx_valid&rx_ready cycle shifts the byte in: word <= {word[23:0], rx_data}; byte index +1.
  - Fourth byte accepted → WRITE.
  - rx_valid=0 stalls indefinitely; no timeout.
- WRITE (1 cycle): if_we=1, if_wins=assembled word, if_newpc=addr+4, rx_ready=0, busy=1.
  - Word counter +1; addr += 4.
  - If counter reaches latched count → BOOT, else → RECV with byte index=0.
- BOOT (1 cycle): if_rst=1, if_we=0, busy=1 → PC=0. Then → RUN.
- RUN: if_rst=0, if_we=0, rx_ready=0, core_run=1, busy=0, if_newpc=core_newpc.
  - On start: apply IDLE's start check; on valid start go CLR with core_run=0 from the same cycle (combinational).
- start in CLR/RECV/WRITE/BOOT: ignored.
- Bytes offered when rx_ready=0 are not consumed.
- addr is 32-bit, 4 × word index; it cannot wrap because count ≤ IMEM_WORDS.
- Load latency: 1 (CLR) + 5 × count cycles with rx_valid held high + 1 (BOOT); core_run asserts the following cycle.
- Assertions:
  - In WRITE, if_pc == addr.
  - if_we and if_rst never both 1.
  - core_run=0 whenever busy=1.

Test Plan:
- Reset: RST=0 for 2 cycles with rx_valid=1 → if_rst=1, if_we=0, core_run=0, rx_ready=0, err=0.
- Load 2 words: start, word_count=2, bytes 20,08,00,05,AC,01,00,00, rx_valid continuous → if_we pulses with if_wins=32'h20080005 at PC=0, then 32'hAC010000 at PC=4. BOOT pulse follows; core_run=1 exactly 12 cycles after start.
- Backpressure: same load with rx_valid toggling every other cycle → identical writes, latency stretched, no byte dropped or duplicated.
- Boundaries:
  - word_count=0 → CLR, BOOT, RUN in 3 cycles, no if_we.
  - word_count=IMEM_WORDS+1 → err=1, remains IDLE.
  - word_count=IMEM_WORDS → last write at PC=4·(IMEM_WORDS−1).
- Reload/reset mid-op:
  - start during RUN → core_run drops the same cycle, reload proceeds.
  - RST=0 asserted during RECV after 2 bytes → IDLE next cycle; a subsequent load starts at byte index 0, PC=0.
